// File: rtl/gpu_pkg.sv
// Shared constants and types for the GPU instruction ingest path.
package gpu_pkg;

  localparam int unsigned INST_W = 82;
  localparam int unsigned HOST_W = 32;

  // Field offsets within a packed drawing instruction.
  localparam int unsigned INST_TYPE = 0;
  localparam int unsigned VERT      = 1;
  localparam int unsigned COORD_LO  = 2;
  localparam int unsigned LAYER     = 50;
  localparam int unsigned FILL_TYPE = 51;
  localparam int unsigned COLOR_LO  = 52;
  localparam int unsigned TEX_LO    = 76;
  localparam int unsigned ALPHA_LO  = 78;

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2
  } phase_e;

  // Final word contributes only the low bits needed to reach INST_W.
  function automatic logic [INST_W-1:0] pack_inst(input logic [HOST_W-1:0] last_word,
                                                  input logic [2*HOST_W-1:0] lo_words);
    return {last_word[INST_W-2*HOST_W-1:0], lo_words};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with separate occupancy counter.
module sync_fifo #(
  parameter int unsigned Width = 82,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CntFull = (PtrW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, tail_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntFull);
  assign count   = count_q;
  assign do_push = push && !full;
  // A pop against an empty FIFO is ignored even if a push lands the same cycle.
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[head_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[tail_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Packs three host words into one instruction and buffers it for the GPU core.
module inst_loader
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [HOST_W-1:0]        host_data,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic                     host_abort,
  input  logic                     read_en,
  output logic [INST_W-1:0]        fifo_data,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  phase_e             phase_q;
  logic [2*HOST_W-1:0] asm_q;
  logic               accept;
  logic               push;
  logic [INST_W-1:0]  push_data;
  logic               unused_host_hi;

  assign unused_host_hi = ^host_data[HOST_W-1:INST_W-2*HOST_W];

  // Ready looks only at the registered full flag; a same-cycle pop does not help.
  assign host_ready = (phase_q != W2) || !fifo_full;
  assign accept     = host_valid && host_ready;
  assign push       = accept && (phase_q == W2) && !host_abort;
  assign push_data  = pack_inst(host_data, asm_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= W0;
      asm_q         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (host_abort) begin
        phase_q <= W0;
      end else if (accept) begin
        unique case (phase_q)
          W0: begin
            asm_q[HOST_W-1:0] <= host_data;
            phase_q           <= W1;
          end
          W1: begin
            asm_q[2*HOST_W-1:HOST_W] <= host_data;
            phase_q                  <= W2;
          end
          W2: phase_q <= W0;
          default: phase_q <= W0;
        endcase
      end
      if (push && fifo_full) overflow_err <= 1'b1;
      if (read_en && fifo_empty) underflow_err <= 1'b1;
    end
  end

  sync_fifo #(
    .Width (INST_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (read_en),
    .wdata (push_data),
    .rdata (fifo_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (count)
  );

endmodule
